// File: rtl/pd_stream_arbiter_if.sv
// Channel, detector and completion signals shared by the stream arbiter and its environment.
// master = arbiter side, slave = channels/detector/consumer side.
interface pd_stream_arbiter_if #(
    parameter int N  = 4,
    parameter int CW = 8
);
    localparam int OW = $clog2(N);

    logic [N-1:0]  ch_valid_i;
    logic [N-1:0]  ch_bit_i;
    logic [N-1:0]  ch_last_i;
    logic [N-1:0]  ch_ready_o;
    logic          det_clr_o;
    logic          det_valid_o;
    logic          det_bit_o;
    logic          det_match_i;
    logic          done_o;
    logic [OW-1:0] done_ch_o;
    logic [CW-1:0] done_cnt_o;
    logic          done_abort_o;
    logic          busy_o;

    modport master (
        input  ch_valid_i, ch_bit_i, ch_last_i, det_match_i,
        output ch_ready_o, det_clr_o, det_valid_o, det_bit_o,
        output done_o, done_ch_o, done_cnt_o, done_abort_o, busy_o
    );

    modport slave (
        output ch_valid_i, ch_bit_i, ch_last_i, det_match_i,
        input  ch_ready_o, det_clr_o, det_valid_o, det_bit_o,
        input  done_o, done_ch_o, done_cnt_o, done_abort_o, busy_o
    );
endinterface

// File: rtl/pd_stream_arbiter.sv
// Round-robin arbiter sharing one bit-serial pattern detector between N channels;
// counts detector matches per burst and emits a completion record per burst.
module pd_stream_arbiter #(
    parameter int N       = 4,
    parameter int CW      = 8,
    parameter int DET_LAT = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    pd_stream_arbiter_if.master bus
);
    localparam int OW  = $clog2(N);
    localparam int OW1 = OW + 1;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int DW  = $clog2(DET_LAT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CLR    = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [OW-1:0]      rr_q, rr_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [TW-1:0]      idle_q, idle_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic               abort_q, abort_d;
    logic [DET_LAT-1:0] vld_pipe_q, vld_pipe_d;

    logic               det_clr_q, det_clr_d;
    logic               det_valid_q, det_valid_d;
    logic               det_bit_q, det_bit_d;
    logic               done_q, done_d;
    logic [OW-1:0]      done_ch_q, done_ch_d;
    logic [CW-1:0]      done_cnt_q, done_cnt_d;
    logic               done_abort_q, done_abort_d;
    logic               busy_q, busy_d;

    logic               pick_vld;
    logic [OW-1:0]      pick;
    logic [OW:0]        cand;
    logic               xfer;

    // First requester at or above rr_q, wrapping; lowest offset wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        cand     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = {1'b0, rr_q} + OW1'(i);
            if (cand >= OW1'(N)) cand = cand - OW1'(N);
            if (bus.ch_valid_i[cand[OW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = cand[OW-1:0];
            end
        end
    end

    always_comb begin
        bus.ch_ready_o = '0;
        if (state_q == STREAM) bus.ch_ready_o[owner_q] = 1'b1;
    end

    assign xfer = (state_q == STREAM) && bus.ch_valid_i[owner_q];

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        idle_d       = idle_q;
        drain_d      = drain_q;
        abort_d      = abort_q;
        done_d       = 1'b0;
        done_ch_d    = done_ch_q;
        done_cnt_d   = done_cnt_q;
        done_abort_d = done_abort_q;

        // Match flag is only meaningful when it lines up with an issued bit.
        if (vld_pipe_q[DET_LAT-1] && bus.det_match_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick;
                    state_d = CLR;
                    cnt_d   = '0;
                    idle_d  = '0;
                end
            end
            CLR: state_d = STREAM;
            STREAM: begin
                if (xfer) begin
                    idle_d = '0;
                    if (bus.ch_last_i[owner_q]) begin
                        state_d = DRAIN;
                        abort_d = 1'b0;
                        drain_d = '0;
                    end
                end else begin
                    idle_d = idle_q + 1'b1;
                    if (idle_d == TW'(TIMEOUT)) begin
                        state_d = DRAIN;
                        abort_d = 1'b1;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                // The last bit's match is sampled this cycle, so report cnt_d.
                if (drain_q == DW'(DET_LAT - 1)) begin
                    done_d       = 1'b1;
                    done_ch_d    = owner_q;
                    done_cnt_d   = cnt_d;
                    done_abort_d = abort_q;
                    rr_d         = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
                    state_d      = IDLE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        det_valid_d = xfer;
        det_bit_d   = xfer & bus.ch_bit_i[owner_q];
        det_clr_d   = (state_d == CLR);
        busy_d      = (state_d != IDLE);

        vld_pipe_d[0] = xfer;
        for (int i = 1; i < DET_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            idle_q       <= '0;
            drain_q      <= '0;
            abort_q      <= 1'b0;
            vld_pipe_q   <= '0;
            det_clr_q    <= 1'b1;
            det_valid_q  <= 1'b0;
            det_bit_q    <= 1'b0;
            done_q       <= 1'b0;
            done_ch_q    <= '0;
            done_cnt_q   <= '0;
            done_abort_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            idle_q       <= idle_d;
            drain_q      <= drain_d;
            abort_q      <= abort_d;
            vld_pipe_q   <= vld_pipe_d;
            det_clr_q    <= det_clr_d;
            det_valid_q  <= det_valid_d;
            det_bit_q    <= det_bit_d;
            done_q       <= done_d;
            done_ch_q    <= done_ch_d;
            done_cnt_q   <= done_cnt_d;
            done_abort_q <= done_abort_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.det_clr_o    = det_clr_q;
    assign bus.det_valid_o  = det_valid_q;
    assign bus.det_bit_o    = det_bit_q;
    assign bus.done_o       = done_q;
    assign bus.done_ch_o    = done_ch_q;
    assign bus.done_cnt_o   = done_cnt_q;
    assign bus.done_abort_o = done_abort_q;
    assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_pd_stream_arbiter.sv
// Directed bench: two arbiters (CW=8 and CW=2) share stimulus and a 1011
// non-overlapping detector model; completion records are queued and checked.
module tb_pd_stream_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] ch_valid = '0, ch_bit = '0, ch_last = '0;
    logic [3:0]   sh;
    logic         match;

    int checks = 0, errors = 0, cyc = 0, rd = 0;
    int clr_n = 0, last_clr_cyc = 0, bad_rdy = 0;
    logic [31:0] hd = '0, dbits = '0;
    int dq_ch[$], dq_cnt[$], dq_ab[$], dq_cyc[$], dq_hd[$], dq_scnt[$];
    int f1, l1, f3, l3;

    pd_stream_arbiter_if #(.N(N), .CW(8)) b_m ();
    pd_stream_arbiter_if #(.N(N), .CW(2)) b_s ();

    assign b_m.ch_valid_i  = ch_valid;
    assign b_m.ch_bit_i    = ch_bit;
    assign b_m.ch_last_i   = ch_last;
    assign b_m.det_match_i = match;
    assign b_s.ch_valid_i  = ch_valid;
    assign b_s.ch_bit_i    = ch_bit;
    assign b_s.ch_last_i   = ch_last;
    assign b_s.det_match_i = match;

    pd_stream_arbiter #(.N(N), .CW(8), .DET_LAT(2), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(b_m));
    pd_stream_arbiter #(.N(N), .CW(2), .DET_LAT(2), .TIMEOUT(16)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .bus(b_s));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Detector: registered match one cycle after the bit is presented.
    always @(posedge clk) begin
        if (b_m.det_clr_o) begin
            sh <= 4'b0; match <= 1'b0;
        end else if (b_m.det_valid_o) begin
            if ({sh[2:0], b_m.det_bit_o} == 4'b1011) begin
                sh <= 4'b0; match <= 1'b1;
            end else begin
                sh <= {sh[2:0], b_m.det_bit_o}; match <= 1'b0;
            end
        end else begin
            match <= 1'b0;
        end
    end

    always @(negedge clk) begin
        hd = {hd[30:0], b_m.det_valid_o};
        if (b_m.det_valid_o) dbits = {dbits[30:0], b_m.det_bit_o};
        if (rst_n && b_m.det_clr_o) begin clr_n++; last_clr_cyc = cyc; end
        if (!$onehot0(b_m.ch_ready_o)) bad_rdy++;
        if (b_m.done_o) begin
            dq_ch.push_back(int'(b_m.done_ch_o));
            dq_cnt.push_back(int'(b_m.done_cnt_o));
            dq_ab.push_back(int'(b_m.done_abort_o));
            dq_cyc.push_back(cyc);
            dq_hd.push_back(int'(hd[9:0]));
            dq_scnt.push_back(int'(b_s.done_cnt_o));
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input int c, input logic b, input logic l, output int xc);
        int n = 0;
        ch_valid[c] = 1'b1; ch_bit[c] = b; ch_last[c] = l;
        @(negedge clk);
        while (!b_m.ch_ready_o[c] && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("ready_timeout", 0, 1);
        xc = cyc;
        @(posedge clk); #1;
        ch_valid[c] = 1'b0; ch_last[c] = 1'b0;
    endtask

    // Sends bits[n-1] first; optional stall of st_len cycles before bit st_at.
    task automatic send_burst(input int c, input logic [31:0] bits, input int n, input logic last,
                              input int st_at, input int st_len, output int fx, output int lx);
        int xc;
        fx = 0; lx = 0;
        for (int i = 0; i < n; i++) begin
            if (i == st_at && st_len > 0) begin repeat (st_len) @(posedge clk); #1; end
            send_bit(c, bits[n-1-i], last && (i == n - 1), xc);
            if (i == 0) fx = xc;
            lx = xc;
        end
    endtask

    task automatic wait_done(output int ch, output int cnt, output int ab, output int dc,
                             output int hdv, output int scnt);
        int n = 0;
        while (rd >= dq_ch.size() && n < 400) begin @(negedge clk); n++; end
        if (rd >= dq_ch.size()) begin
            chk("done_timeout", 0, 1);
            ch = -1; cnt = -1; ab = -1; dc = -1; hdv = -1; scnt = -1;
        end else begin
            ch = dq_ch[rd]; cnt = dq_cnt[rd]; ab = dq_ab[rd];
            dc = dq_cyc[rd]; hdv = dq_hd[rd]; scnt = dq_scnt[rd];
            rd++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int f, l, ch, cnt, ab, dc, hdv, sc, clr0, n0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", int'(b_m.done_o), 0);
        chk("rst_det_valid", int'(b_m.det_valid_o), 0);
        chk("rst_ready", int'(b_m.ch_ready_o), 0);
        chk("rst_busy", int'(b_m.busy_o), 0);
        chk("rst_det_clr", int'(b_m.det_clr_o), 1);
        chk("rst_done_cnt", int'(b_m.done_cnt_o), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ch0: 1011 -> one match, fixed latency
        clr0 = clr_n;
        send_burst(0, 32'b1011, 4, 1'b1, -1, 0, f, l);
        wait_done(ch, cnt, ab, dc, hdv, sc);
        chk("t1_ch", ch, 0);
        chk("t1_cnt", cnt, 1);
        chk("t1_abort", ab, 0);
        chk("t1_latency", dc - l, 3);
        chk("t1_clr_to_ready", f - last_clr_cyc, 1);
        chk("t1_clr_pulses", clr_n - clr0, 1);
        chk("t1_det_bits", int'(dbits[3:0]), 11);

        // ch2: 1011 1011 -> two matches
        send_burst(2, 32'b10111011, 8, 1'b1, -1, 0, f, l);
        wait_done(ch, cnt, ab, dc, hdv, sc);
        chk("t2_ch", ch, 2);
        chk("t2_cnt", cnt, 2);
        chk("t2_abort", ab, 0);

        // ch3: single-bit burst
        send_burst(3, 32'b1, 1, 1'b1, -1, 0, f, l);
        wait_done(ch, cnt, ab, dc, hdv, sc);
        chk("t3_ch", ch, 3);
        chk("t3_cnt", cnt, 0);
        chk("t3_abort", ab, 0);
        chk("t3_latency", dc - l, 3);

        // from reset: ch1 and ch3 together, ch1 re-requests during ch3
        do_reset();
        fork
            begin
                send_burst(1, 32'b10, 2, 1'b1, -1, 0, f1, l1);
                repeat (5) @(posedge clk);
                #1;
                send_burst(1, 32'b11, 2, 1'b1, -1, 0, f1, l1);
            end
            send_burst(3, 32'b1011, 4, 1'b1, -1, 0, f3, l3);
        join
        wait_done(ch, cnt, ab, dc, hdv, sc);
        chk("rr_first", ch, 1);
        wait_done(ch, cnt, ab, dc, hdv, sc);
        chk("rr_second", ch, 3);
        chk("rr_second_cnt", cnt, 1);
        wait_done(ch, cnt, ab, dc, hdv, sc);
        chk("rr_third", ch, 1);

        // ch0 stall of 3 mid-burst: gaps in det_valid mirror the stall
        send_burst(0, 32'b1011, 4, 1'b1, 2, 3, f, l);
        wait_done(ch, cnt, ab, dc, hdv, sc);
        chk("stall3_ch", ch, 0);
        chk("stall3_cnt", cnt, 1);
        chk("stall3_abort", ab, 0);
        chk("stall3_det_valid", hdv, 10'b0110001100);

        // stall of 15 is one short of the timeout
        send_burst(0, 32'b1011, 4, 1'b1, 2, 15, f, l);
        wait_done(ch, cnt, ab, dc, hdv, sc);
        chk("stall15_cnt", cnt, 1);
        chk("stall15_abort", ab, 0);

        // no last, then silence -> timeout abort with partial count
        send_burst(0, 32'b10111, 5, 1'b0, -1, 0, f, l);
        wait_done(ch, cnt, ab, dc, hdv, sc);
        chk("abort_ch", ch, 0);
        chk("abort_cnt", cnt, 1);
        chk("abort_flag", ab, 1);
        chk("abort_latency", dc - l, 19);

        // five matches: CW=8 counts 5, CW=2 saturates at 3
        send_burst(1, 32'hBBBBB, 20, 1'b1, -1, 0, f, l);
        wait_done(ch, cnt, ab, dc, hdv, sc);
        chk("sat_ch", ch, 1);
        chk("sat_cnt_cw8", cnt, 5);
        chk("sat_cnt_cw2", sc, 3);

        // reset mid-burst on ch2
        send_bit(2, 1'b1, 1'b0, f);
        send_bit(2, 1'b0, 1'b0, f);
        ch_valid[2] = 1'b1; ch_bit[2] = 1'b1;
        n0 = dq_ch.size();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_done", int'(b_m.done_o), 0);
        chk("mid_rst_det_valid", int'(b_m.det_valid_o), 0);
        chk("mid_rst_det_clr", int'(b_m.det_clr_o), 1);
        chk("mid_rst_ready", int'(b_m.ch_ready_o), 0);
        chk("mid_rst_busy", int'(b_m.busy_o), 0);
        chk("mid_rst_done_cnt", int'(b_m.done_cnt_o), 0);
        chk("mid_rst_done_ch", int'(b_m.done_ch_o), 0);
        ch_valid[2] = 1'b0; ch_bit[2] = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_no_done", dq_ch.size() - n0, 0);
        fork
            send_burst(0, 32'b1, 1, 1'b1, -1, 0, f1, l1);
            send_burst(3, 32'b1, 1, 1'b1, -1, 0, f3, l3);
        join
        wait_done(ch, cnt, ab, dc, hdv, sc);
        chk("post_rst_first", ch, 0);
        wait_done(ch, cnt, ab, dc, hdv, sc);
        chk("post_rst_second", ch, 3);

        chk("ready_onehot", bad_rdy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
